// File: rtl/odve_uart_rx.sv
// UART receiver with 2-flop input synchronizer, oversampled mid-bit sampling,
// optional parity, and a single-entry valid/ready output register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | confirming the start bit at its mid-point (glitch reject)
// DATA   | sampling DATA_W data bits mid-bit, LSB first
// PARITY | sampling the parity bit (only reachable when PARITY_EN=1)
// STOP   | sampling the stop bit, then delivering or dropping the word
module odve_uart_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVS        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       baud_div,
  input  logic              rx_i,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int OS_W = $clog2(OVS);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 - 1);
  localparam logic [OS_W-1:0] OS_END  = OS_W'(OVS - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
  localparam logic            PAR_EN  = (PARITY_EN != 0);
  localparam logic            PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  logic [1:0]        sync_fill;
  logic [15:0]       div_cnt;
  logic              tick;
  logic              start_edge;
  logic [OS_W-1:0]   os_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_err_q;

  // Synchronize rx_i; rx_prev only reports 1 once rx_s carries a post-reset
  // sample, so the reset value of the synchronizer can never fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= rx_i;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= rx_s & sync_fill[1];
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_s;

  // Oversample tick generator; >= keeps it from running away if baud_div shrinks.
  assign tick = (div_cnt >= baud_div);

  // Tick counter, realigned to the start edge so mid-bit sampling is centred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (start_edge || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Receive FSM with output register and overrun detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          os_cnt <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          if (tick) begin
            if (os_cnt == OS_MID) begin
              os_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state     <= DATA;
                bit_cnt   <= '0;
                par_err_q <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == OS_END) begin
              os_cnt <= '0;
              shreg  <= {rx_s, shreg[DATA_W-1:1]};
              if (bit_cnt == BC_LAST) begin
                state <= PAR_EN ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (os_cnt == OS_END) begin
              os_cnt    <= '0;
              par_err_q <= ((^shreg) ^ rx_s) != PAR_ODD;
              state     <= STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == OS_END) begin
              os_cnt <= '0;
              state  <= IDLE;
              // Word is accepted if the register is empty or being drained now.
              if (!m_valid || m_ready) begin
                m_data     <= shreg;
                frame_err  <= ~rx_s;
                parity_err <= par_err_q;
                m_valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
